// File: rtl/link_ctrl_pkg.sv
// link_ctrl_pkg: state encoding, counter widths and timer sizing for link_ctrl.
package link_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RST       = 3'd0,
    S_WAIT_TX   = 3'd1,
    S_WAIT_RX   = 3'd2,
    S_WAIT_LOCK = 3'd3,
    S_STABLE    = 3'd4,
    S_UP        = 3'd5,
    S_HOLD      = 3'd6
  } link_state_t;

  localparam int unsigned RETRY_W = 8;
  localparam int unsigned DROP_W  = 16;

  // Bits needed to hold N-1 for the largest dwell.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d,
                                              input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/link_ctrl_if.sv
// link_ctrl_if: lane status inputs and control/debug outputs of the link sequencer.
interface link_ctrl_if;
  import link_ctrl_pkg::*;

  logic               force_linkdown;
  logic               pma_tx_rdy;
  logic               pma_rx_rdy;
  logic               pma_sync;
  logic               xcvr_rst;
  logic               pcs_rst;
  logic               tx_en;
  logic               link_up;
  logic [2:0]         state;
  logic [RETRY_W-1:0] retry_cnt;
  logic [DROP_W-1:0]  drop_cnt;

  modport master (
    input  force_linkdown, pma_tx_rdy, pma_rx_rdy, pma_sync,
    output xcvr_rst, pcs_rst, tx_en, link_up, state, retry_cnt, drop_cnt
  );

  modport slave (
    output force_linkdown, pma_tx_rdy, pma_rx_rdy, pma_sync,
    input  xcvr_rst, pcs_rst, tx_en, link_up, state, retry_cnt, drop_cnt
  );

endinterface

// File: rtl/link_ctrl_timer.sv
// ctrl_timer: loadable down-counter that parks at zero; done while the count is zero.
module ctrl_timer #(
  parameter int unsigned     W       = 16,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load on request, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (rst)             cnt <= RST_VAL;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/link_ctrl.sv
// link_ctrl: bring-up/recovery sequencer for one 10GBASE-R lane.
// Optional feature: define LINK_CTRL_STATS_EN to build the UP->HOLD drop counter;
// otherwise drop_cnt is tied to zero.
module link_ctrl
  import link_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYC     = 16,
  parameter int unsigned TX_TO       = 1024,
  parameter int unsigned LOCK_TO     = 65536,
  parameter int unsigned LOCK_STABLE = 64,
  parameter int unsigned DOWN_HOLD   = 256
) (
  input  logic        clk,
  input  logic        rst,
  link_ctrl_if.master lnk
);

  localparam int unsigned TW = timer_width(RST_CYC, TX_TO, LOCK_TO, LOCK_STABLE, DOWN_HOLD);

  logic [3:0]         sync_meta;
  logic [3:0]         sync_q;
  logic               force_s, tx_rdy_s, rx_rdy_s, sync_s;
  link_state_t        state_q, nxt;
  logic               retry_inc;
  logic               tmr_load, tmr_done;
  logic [TW-1:0]      tmr_val;
  logic               xcvr_rst_q, pcs_rst_q, tx_en_q, link_up_q;
  logic [RETRY_W-1:0] retry_q;

  // Dwell length (minus one) loaded on entry to each timed state.
  function automatic logic [TW-1:0] dwell(input link_state_t s);
    case (s)
      S_RST:       return TW'(RST_CYC - 1);
      S_WAIT_TX:   return TW'(TX_TO - 1);
      S_WAIT_RX:   return TW'(TX_TO - 1);
      S_WAIT_LOCK: return TW'(LOCK_TO - 1);
      S_STABLE:    return TW'(LOCK_STABLE - 1);
      S_HOLD:      return TW'(DOWN_HOLD - 1);
      default:     return '0;
    endcase
  endfunction

  // Two-flop synchronisers for the asynchronous lane status levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {lnk.force_linkdown, lnk.pma_tx_rdy, lnk.pma_rx_rdy, lnk.pma_sync};
      sync_q    <= sync_meta;
    end
  end

  assign force_s  = sync_q[3];
  assign tx_rdy_s = sync_q[2];
  assign rx_rdy_s = sync_q[1];
  assign sync_s   = sync_q[0];

  // Next-state selection: force, then TX-ready loss, then per-state progress.
  always_comb begin
    nxt       = state_q;
    retry_inc = 1'b0;
    if (force_s) begin
      nxt = S_RST;
    end else if (!tx_rdy_s && (state_q == S_WAIT_RX || state_q == S_WAIT_LOCK ||
                               state_q == S_STABLE  || state_q == S_UP || state_q == S_HOLD)) begin
      nxt       = S_RST;
      retry_inc = 1'b1;
    end else begin
      case (state_q)
        S_RST:       if (tmr_done) nxt = S_WAIT_TX;
        S_WAIT_TX:   if (tx_rdy_s) nxt = S_WAIT_RX;
                     else if (tmr_done) begin nxt = S_RST; retry_inc = 1'b1; end
        S_WAIT_RX:   if (rx_rdy_s) nxt = S_WAIT_LOCK;
                     else if (tmr_done) begin nxt = S_RST; retry_inc = 1'b1; end
        S_WAIT_LOCK: if (sync_s) nxt = S_STABLE;
                     else if (tmr_done) begin nxt = S_RST; retry_inc = 1'b1; end
        S_STABLE:    if (!sync_s) nxt = S_WAIT_LOCK;
                     else if (tmr_done) nxt = S_UP;
        S_UP:        if (!sync_s || !rx_rdy_s) nxt = S_HOLD;
        S_HOLD:      if (tmr_done) begin
                       if (rx_rdy_s) nxt = S_WAIT_LOCK;
                       else begin nxt = S_RST; retry_inc = 1'b1; end
                     end
        default:     nxt = S_RST;
      endcase
    end
  end

  // Every state change reloads the timer with the new state's dwell; force keeps
  // reloading so S_RST always lasts RST_CYC cycles after force is released.
  assign tmr_load = force_s || (nxt != state_q);
  assign tmr_val  = dwell(nxt);

  ctrl_timer #(
    .W       (TW),
    .RST_VAL (TW'(RST_CYC - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State register with outputs decoded from the next state, plus retry counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RST;
      xcvr_rst_q <= 1'b1;
      pcs_rst_q  <= 1'b1;
      tx_en_q    <= 1'b0;
      link_up_q  <= 1'b0;
      retry_q    <= '0;
    end else begin
      state_q    <= nxt;
      xcvr_rst_q <= (nxt == S_RST);
      pcs_rst_q  <= (nxt == S_RST) || (nxt == S_WAIT_TX) || (nxt == S_WAIT_RX);
      tx_en_q    <= (nxt == S_WAIT_RX) || (nxt == S_WAIT_LOCK) || (nxt == S_STABLE) ||
                    (nxt == S_UP) || (nxt == S_HOLD);
      link_up_q  <= (nxt == S_UP);
      if (retry_inc && retry_q != '1) retry_q <= retry_q + RETRY_W'(1);
    end
  end

`ifdef LINK_CTRL_STATS_EN
  logic [DROP_W-1:0] drop_q;

  // Count UP->HOLD transitions, saturating.
  always_ff @(posedge clk) begin
    if (rst)
      drop_q <= '0;
    else if (state_q == S_UP && nxt == S_HOLD && drop_q != '1)
      drop_q <= drop_q + DROP_W'(1);
  end

  assign lnk.drop_cnt = drop_q;
`else
  assign lnk.drop_cnt = '0;
`endif

  assign lnk.xcvr_rst  = xcvr_rst_q;
  assign lnk.pcs_rst   = pcs_rst_q;
  assign lnk.tx_en     = tx_en_q;
  assign lnk.link_up   = link_up_q;
  assign lnk.state     = state_q;
  assign lnk.retry_cnt = retry_q;

endmodule
